cam_entry_writer: RTL

Write-side controller and storage for the 32-entry x 32-bit CAM entry array. It accepts commands over a valid/ready handshake: indexed write, allocate-to-first-free, invalidate, and flush. It holds the registered entry array and valid bits. The flat entry array feeds the existing 32:1 read-select path, so this block is the writer end of the same entry-index interface.

---
 rtl/cam_pkg.sv | 24 ++
 rtl/cam_free_prio_enc.sv | 25 ++
 rtl/cam_entry_writer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared CAM types and array dimensions
//
// Used by the entry writer and the read-select path.
// CAM_NUM_ENTRIES and CAM_WIDTH give the default array size.
// cam_op_e is the writer command opcode.
// cam_wr_state_e is the writer FSM state.
package cam_pkg;

  localparam int CAM_NUM_ENTRIES = 32;
  localparam int CAM_WIDTH       = 32;

  typedef enum logic [1:0] {
    OP_WRITE_IDX = 2'd0,
    OP_ALLOC     = 2'd1,
    OP_INVAL     = 2'd2,
    OP_FLUSH     = 2'd3
  } cam_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } cam_wr_state_e;

endpackage

// File: rtl/cam_free_prio_enc.sv
// rtl/cam_free_prio_enc.sv - lowest-free-entry priority encoder
//
// Finds the lowest entry index whose valid bit is clear.
//   valid    : per-entry valid bits
//   free_idx : lowest index with valid == 0 (0 when none is free)
//   any_free : at least one entry is free
module cam_free_prio_enc #(
  parameter int NUM_ENTRIES = 32,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic [NUM_ENTRIES-1:0] valid,
  output logic [IDX_W-1:0]       free_idx,
  output logic                   any_free
);

  // Scanning from the top down lets the lowest free index win.
  always_comb begin
    free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) free_idx = IDX_W'(i);
    end
    any_free = ~&valid;
  end

endmodule

// File: rtl/cam_entry_writer.sv
// rtl/cam_entry_writer.sv - CAM entry array write controller and storage
//
// Accepts WRITE_IDX, ALLOC, INVAL and FLUSH commands over a valid/ready handshake.
// It holds the registered entry array and the valid bits.
//   clk_i, rst_ni          : clock, async active-low reset
//   cmd_v_i / cmd_ready_o  : command handshake (ready only in IDLE)
//   cmd_op_i, cmd_idx_i,
//   cmd_data_i             : opcode, target index, write data
//   resp_v_o, resp_idx_o,
//   resp_err_o             : one-cycle completion pulse, index, alloc-full error
//   entries_o, valid_o     : registered entry array and valid bits
//   count_o, full_o        : popcount of valid_o, and the array-full flag
module cam_entry_writer
  import cam_pkg::*;
#(
  parameter int NUM_ENTRIES = CAM_NUM_ENTRIES,
  parameter int WIDTH       = CAM_WIDTH,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              cmd_v_i,
  output logic                              cmd_ready_o,
  input  logic [1:0]                        cmd_op_i,
  input  logic [IDX_W-1:0]                  cmd_idx_i,
  input  logic [WIDTH-1:0]                  cmd_data_i,
  output logic                              resp_v_o,
  output logic [IDX_W-1:0]                  resp_idx_o,
  output logic                              resp_err_o,
  output logic [NUM_ENTRIES-1:0][WIDTH-1:0] entries_o,
  output logic [NUM_ENTRIES-1:0]            valid_o,
  output logic [IDX_W:0]                    count_o,
  output logic                              full_o
);

  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(NUM_ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  cam_wr_state_e    state_q;
  logic [IDX_W-1:0] sweep_q;
  logic [IDX_W-1:0] free_idx;
  logic             any_free;
  logic [IDX_W:0]   count_nxt;
  cam_op_e          op;
  logic             accept;

  assign op          = cam_op_e'(cmd_op_i);
  assign cmd_ready_o = (state_q == ST_IDLE);
  assign accept      = cmd_v_i & cmd_ready_o;

  cam_free_prio_enc #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_free_enc (
    .valid    (valid_o),
    .free_idx (free_idx),
    .any_free (any_free)
  );

  // The count tracks each valid-bit transition on the edge where it happens.
  // This keeps count_o equal to popcount(valid_o) without an adder tree.
  always_comb begin
    count_nxt = count_o;
    if (state_q == ST_FLUSH) begin
      if (valid_o[sweep_q]) count_nxt = count_o - CNT_ONE;
    end else if (accept) begin
      case (op)
        OP_WRITE_IDX: if (!valid_o[cmd_idx_i]) count_nxt = count_o + CNT_ONE;
        OP_ALLOC:     if (any_free)            count_nxt = count_o + CNT_ONE;
        OP_INVAL:     if (valid_o[cmd_idx_i])  count_nxt = count_o - CNT_ONE;
        default:      count_nxt = count_o;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      sweep_q    <= '0;
      entries_o  <= '0;
      valid_o    <= '0;
      count_o    <= '0;
      full_o     <= 1'b0;
      resp_v_o   <= 1'b0;
      resp_idx_o <= '0;
      resp_err_o <= 1'b0;
    end else begin
      resp_v_o   <= 1'b0;
      resp_idx_o <= '0;
      resp_err_o <= 1'b0;
      count_o    <= count_nxt;
      full_o     <= (count_nxt == CNT_FULL);
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            case (op)
              OP_WRITE_IDX: begin
                entries_o[cmd_idx_i] <= cmd_data_i;
                valid_o[cmd_idx_i]   <= 1'b1;
                resp_v_o             <= 1'b1;
                resp_idx_o           <= cmd_idx_i;
              end
              OP_ALLOC: begin
                resp_v_o <= 1'b1;
                if (any_free) begin
                  entries_o[free_idx] <= cmd_data_i;
                  valid_o[free_idx]   <= 1'b1;
                  resp_idx_o          <= free_idx;
                end else begin
                  resp_err_o <= 1'b1;
                end
              end
              OP_INVAL: begin
                // Only the valid bit is cleared; the stale data stays readable.
                valid_o[cmd_idx_i] <= 1'b0;
                resp_v_o           <= 1'b1;
                resp_idx_o         <= cmd_idx_i;
              end
              default: begin
                state_q <= ST_FLUSH;
                sweep_q <= '0;
              end
            endcase
          end
        end
        ST_FLUSH: begin
          entries_o[sweep_q] <= '0;
          valid_o[sweep_q]   <= 1'b0;
          sweep_q            <= sweep_q + 1'b1;
          if (sweep_q == LAST_IDX) begin
            state_q  <= ST_IDLE;
            resp_v_o <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
